act_lut_pipeline: RTL

Pipelined, parametrised activation unit for the LSTM datapath, serving both tanh and sigmoid from one shared synchronous LUT ROM.
- Per-sample mode select.
- Generalised address scaling, with every range and scale constant exposed as a parameter.
- Symmetry reconstruction for negative inputs and closed-form saturation/linear regions.
- Valid/ready streaming with full backpressure.
- Sits between the gate pre-activation adders and the cell-state/hidden-state multipliers.

---
 rtl/act_pkg.sv | 32 +++
 rtl/act_addr_calc.sv | 51 +++++
 rtl/act_lut_pipeline.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared constants and encodings for the LSTM activation unit.
package act_pkg;

  // Per-sample function select carried alongside each sample.
  typedef enum logic {
    MODE_TANH    = 1'b0,
    MODE_SIGMOID = 1'b1
  } act_mode_e;

  // Default fixed-point format (S7.8) and LUT range/scale settings.
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FRAC_BITS   = 8;
  localparam int DEF_ADDR_WIDTH  = 9;
  localparam int DEF_IN_MIN      = 64;   // 0.25
  localparam int DEF_IN_MAX      = 768;  // 3.0
  localparam int DEF_SCALE_MUL   = 51;
  localparam int DEF_SCALE_SHIFT = 7;
  localparam int DEF_MAX_ADDR    = 275;

  // 1.0 and 0.5 in a format with the given number of fractional bits.
  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int fx_half(input int frac);
    return 1 << (frac - 1);
  endfunction

  localparam int ONE  = fx_one(DEF_FRAC_BITS);
  localparam int HALF = fx_half(DEF_FRAC_BITS);

endpackage

// File: rtl/act_addr_calc.sv
// Combinational front end: |x|, saturation region flags and scaled LUT address.
module act_addr_calc
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int IN_MIN      = DEF_IN_MIN,
  parameter int IN_MAX      = DEF_IN_MAX,
  parameter int SCALE_MUL   = DEF_SCALE_MUL,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int MAX_ADDR    = DEF_MAX_ADDR
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic                  neg,
  output logic                  sat_lo,
  output logic                  sat_hi,
  output logic [ADDR_WIDTH-1:0] addr
);

  // Product is kept at full width so nothing is lost before the shift.
  localparam int MW = DATA_WIDTH + $clog2(SCALE_MUL) + 1;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [DATA_WIDTH-1:0] abs_v;
  logic [DATA_WIDTH-1:0] diff;
  logic [MW-1:0]         prod;
  logic [MW-1:0]         scaled;

  // Magnitude, region classification and clamped address in one pass.
  always_comb begin
    neg = x[DATA_WIDTH-1];
    // -MOST_NEG does not exist; saturate it to the largest positive value.
    if (x == MOST_NEG)  abs_v = MOST_POS;
    else if (neg)       abs_v = '0 - x;
    else                abs_v = x;

    sat_lo = abs_v < DATA_WIDTH'(IN_MIN);
    sat_hi = abs_v > DATA_WIDTH'(IN_MAX);

    diff   = abs_v - DATA_WIDTH'(IN_MIN);
    prod   = MW'(diff) * MW'(SCALE_MUL);
    scaled = prod >> SCALE_SHIFT;

    if (sat_lo || sat_hi)            addr = '0;
    else if (scaled > MW'(MAX_ADDR)) addr = ADDR_WIDTH'(MAX_ADDR);
    else                             addr = scaled[ADDR_WIDTH-1:0];
  end

endmodule

// File: rtl/act_lut_pipeline.sv
// Pipelined tanh/sigmoid unit over one shared 1-cycle-latency LUT ROM.
// Stage 0 issues the ROM read, stage 1 waits for the data (holding it if
// the output is stalled), the output register reconstructs f(x).
module act_lut_pipeline
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int IN_MIN      = DEF_IN_MIN,
  parameter int IN_MAX      = DEF_IN_MAX,
  parameter int SCALE_MUL   = DEF_SCALE_MUL,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int MAX_ADDR    = DEF_MAX_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  rom_en,
  output logic [ADDR_WIDTH:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_mode
);

  localparam logic [DATA_WIDTH-1:0] ONE_V  = DATA_WIDTH'(fx_one(FRAC_BITS));
  localparam logic [DATA_WIDTH-1:0] HALF_V = DATA_WIDTH'(fx_half(FRAC_BITS));

  // Stage 0
  logic                  s0_neg, s0_lo, s0_hi;
  logic [ADDR_WIDTH-1:0] s0_addr;
  logic                  accept;

  // Stage 1
  logic                         s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH-1:0] s1_x_q, s1_x_d;
  logic                         s1_mode_q, s1_mode_d;
  logic                         s1_neg_q, s1_neg_d;
  logic                         s1_lo_q, s1_lo_d;
  logic                         s1_hi_q, s1_hi_d;
  logic                         s1_advance;

  // ROM data hold while stage 1 is stalled
  logic                  hold_q, hold_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  // Output register
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_mode_q, out_mode_d;

  logic [DATA_WIDTH-1:0]        lut;
  logic signed [DATA_WIDTH-1:0] x_sh;
  logic [DATA_WIDTH-1:0]        result;

  act_addr_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IN_MIN     (IN_MIN),
    .IN_MAX     (IN_MAX),
    .SCALE_MUL  (SCALE_MUL),
    .SCALE_SHIFT(SCALE_SHIFT),
    .MAX_ADDR   (MAX_ADDR)
  ) u_addr_calc (
    .x     (in_data),
    .neg   (s0_neg),
    .sat_lo(s0_lo),
    .sat_hi(s0_hi),
    .addr  (s0_addr)
  );

  // Stage 1 moves into the output register whenever that register is free
  // or being popped; this is also what frees stage 1 for a new sample.
  assign s1_advance = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | s1_advance;
  assign accept     = in_valid & in_ready;
  assign rom_en     = accept;
  assign rom_addr   = {in_mode, s0_addr};

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_mode   = out_mode_q;

  // Stage-1 capture of the sample metadata on accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_mode_d  = s1_mode_q;
    s1_neg_d   = s1_neg_q;
    s1_lo_d    = s1_lo_q;
    s1_hi_d    = s1_hi_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = in_data;
      s1_mode_d  = in_mode;
      s1_neg_d   = s0_neg;
      s1_lo_d    = s0_lo;
      s1_hi_d    = s0_hi;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // rom_rdata is only valid in the first stage-1 cycle; keep it if stuck.
  always_comb begin
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
    if (s1_advance) begin
      hold_d = 1'b0;
    end else if (s1_valid_q && !hold_q) begin
      hold_d      = 1'b1;
      hold_data_d = rom_rdata;
    end
  end

  // Rebuild f(x) from f(|x|) using odd/point symmetry and closed-form tails.
  always_comb begin
    lut    = hold_q ? hold_data_q : rom_rdata;
    x_sh   = s1_x_q >>> 2;
    result = '0;
    if (s1_mode_q == MODE_SIGMOID) begin
      if (s1_lo_q)      result = HALF_V + x_sh;
      else if (s1_hi_q) result = s1_neg_q ? '0 : ONE_V;
      else              result = s1_neg_q ? ONE_V - lut : lut;
    end else begin
      if (s1_lo_q)      result = s1_x_q;
      else if (s1_hi_q) result = s1_neg_q ? '0 - ONE_V : ONE_V;
      else              result = s1_neg_q ? '0 - lut : lut;
    end
  end

  // Output register load/pop.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    if (s1_advance) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_mode_d  = s1_mode_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state and visible outputs; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      hold_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
    end
  end

  // Datapath registers qualified by the valid/hold flags, no reset needed.
  always_ff @(posedge clk) begin
    s1_x_q      <= s1_x_d;
    s1_mode_q   <= s1_mode_d;
    s1_neg_q    <= s1_neg_d;
    s1_lo_q     <= s1_lo_d;
    s1_hi_q     <= s1_hi_d;
    hold_data_q <= hold_data_d;
  end

endmodule
